// File: rtl/sdram_mux_bus_pkg.sv
// Shared types and constants for the sdram_mux_bus client arbiter.
package sdram_bus_pkg;

    typedef enum logic {OP_READ, OP_WRITE} sdram_op_e;
    typedef enum logic {IDLE, ISSUE} state_e;

    // Wide enough for up to 8 clients.
    localparam int TAG_CLIENT_W = 3;

    typedef struct packed {
        logic [TAG_CLIENT_W-1:0] client;
        logic                    lane;
    } rd_tag_t;

    localparam logic [3:0] BE_LO_N = 4'b1100;
    localparam logic [3:0] BE_HI_N = 4'b0011;

    function automatic logic [3:0] lane_be_n(input logic lane);
        return lane ? BE_HI_N : BE_LO_N;
    endfunction

endpackage

// File: rtl/sdram_mux_bus_if.sv
// Avalon-MM link between sdram_mux_bus (master) and new_sdram_controller_0 s1 (slave).
interface sdram_mux_bus_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-2:0] address;
    logic [3:0]        byteenable_n;
    logic              chipselect;
    logic [31:0]       writedata;
    logic              read_n;
    logic              write_n;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, byteenable_n, chipselect, writedata, read_n, write_n,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable_n, chipselect, writedata, read_n, write_n,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sdram_mux_bus_tag_fifo.sv
// Read-tag FIFO: remembers {client, lane} of each read accepted by the controller.
module sdram_rd_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/sdram_mux_bus.sv
// N-client 16-bit to 32-bit Avalon SDRAM arbiter with pipelined tagged reads.
// Define SDRAM_MUX_BUS_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sdram_mux_bus
    import sdram_bus_pkg::*;
#(
    parameter int N_CLIENTS       = 2,
    parameter int ADDR_W          = 24,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_CLIENTS*ADDR_W-1:0] client_addr,
    input  logic [N_CLIENTS-1:0]      client_read,
    input  logic [N_CLIENTS-1:0]      client_write,
    input  logic [N_CLIENTS*16-1:0]   client_writedata,
    output logic [N_CLIENTS-1:0]      client_accepted,
    output logic [N_CLIENTS-1:0]      client_readvalid,
    output logic [15:0]               client_readdata,
    output logic                      err_underflow,
    sdram_mux_bus_if.master           new_sdram_controller_0_s1
);
    localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int TW = CW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    state_e            state_q, state_d;
    sdram_op_e         op_q, op_d;
    logic [CW-1:0]     gnt_q, gnt_d;
    logic [ADDR_W-2:0] waddr_q, waddr_d;
    logic              lane_q, lane_d;
    logic [15:0]       wd_q, wd_d;
    logic [OW-1:0]     outst_q;
    logic [N_CLIENTS-1:0] rv_q, rv_d;
    logic [15:0]       rdata_q;
    logic              err_q;

    logic [N_CLIENTS-1:0] elig;
    logic              found;
    logic [CW-1:0]     pick, cand;
    logic              tag_push, tag_pop, tag_full, tag_empty;
    logic [TW-1:0]     tag_dout;
    rd_tag_t           head;
    logic              issue;

`ifndef SDRAM_MUX_BUS_FIXED_PRIO_EN
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    // Reads wait while the controller already holds MAX_OUTSTANDING of them.
    always_comb begin
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            elig[i] = client_write[i] | (client_read[i] & (outst_q != OW'(MAX_OUTSTANDING)));
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
`ifdef SDRAM_MUX_BUS_FIXED_PRIO_EN
            cand = CW'(k);
`else
            cand = CW'((32'(rr_ptr_q) + k) % N_CLIENTS);
`endif
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        gnt_d           = gnt_q;
        waddr_d         = waddr_q;
        lane_d          = lane_q;
        wd_d            = wd_q;
        client_accepted = '0;
        tag_push        = 1'b0;
`ifndef SDRAM_MUX_BUS_FIXED_PRIO_EN
        rr_ptr_d        = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    op_d    = client_write[pick] ? OP_WRITE : OP_READ;
                    waddr_d = client_addr[pick*ADDR_W + 1 +: ADDR_W-1];
                    lane_d  = client_addr[pick*ADDR_W];
                    wd_d    = client_writedata[pick*16 +: 16];
                    state_d = ISSUE;
`ifndef SDRAM_MUX_BUS_FIXED_PRIO_EN
                    rr_ptr_d = (pick == CW'(N_CLIENTS-1)) ? '0 : pick + 1'b1;
`endif
                end
            end
            ISSUE: begin
                if (!new_sdram_controller_0_s1.waitrequest) begin
                    client_accepted[gnt_q] = 1'b1;
                    tag_push = (op_q == OP_READ) && (!tag_full || tag_pop);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            gnt_q   <= '0;
            waddr_q <= '0;
            lane_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            wd_q    <= wd_d;
        end
    end

`ifndef SDRAM_MUX_BUS_FIXED_PRIO_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign issue = (state_q == ISSUE);
    assign new_sdram_controller_0_s1.chipselect   = 1'b1;
    assign new_sdram_controller_0_s1.address      = waddr_q;
    assign new_sdram_controller_0_s1.writedata    = lane_q ? {wd_q, 16'h0000} : {16'h0000, wd_q};
    assign new_sdram_controller_0_s1.byteenable_n = issue ? lane_be_n(lane_q) : 4'b1111;
    assign new_sdram_controller_0_s1.read_n       = ~(issue && op_q == OP_READ);
    assign new_sdram_controller_0_s1.write_n      = ~(issue && op_q == OP_WRITE);

    sdram_rd_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (TW)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push_i  (tag_push),
        .din_i   ({gnt_q, lane_q}),
        .pop_i   (tag_pop),
        .dout_o  (tag_dout),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // A beat with no tag queued has no owner and is dropped.
    assign tag_pop = new_sdram_controller_0_s1.readdatavalid & ~tag_empty;

    always_comb begin
        head.client = TAG_CLIENT_W'(tag_dout[TW-1:1]);
        head.lane   = tag_dout[0];
        rv_d        = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            rv_d[i] = tag_pop && (head.client == TAG_CLIENT_W'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rv_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            outst_q <= '0;
        end else begin
            rv_q <= rv_d;
            if (tag_pop) begin
                rdata_q <= head.lane ? new_sdram_controller_0_s1.readdata[31:16]
                                     : new_sdram_controller_0_s1.readdata[15:0];
            end
            if (new_sdram_controller_0_s1.readdatavalid && tag_empty) err_q <= 1'b1;
            if (tag_push && !tag_pop)      outst_q <= outst_q + 1'b1;
            else if (tag_pop && !tag_push) outst_q <= outst_q - 1'b1;
        end
    end

    assign client_readvalid = rv_q;
    assign client_readdata  = rdata_q;
    assign err_underflow    = err_q;
endmodule

// File: tb/tb_sdram_mux_bus.sv
// Self-checking bench for sdram_mux_bus: directed scenarios plus randomized traffic against a cycle model.
module tb_sdram_mux_bus;
    localparam int N    = 2;
    localparam int AW   = 24;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N*AW-1:0] c_addr;
    logic [N-1:0]    c_rd, c_wr;
    logic [N*16-1:0] c_wd;
    logic [N-1:0]    c_acc, c_rv;
    logic [15:0]     c_rdata;
    logic            err;

    sdram_mux_bus_if #(.ADDR_W(AW)) s1();

    sdram_mux_bus #(
        .N_CLIENTS       (N),
        .ADDR_W          (AW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .client_addr               (c_addr),
        .client_read               (c_rd),
        .client_write              (c_wr),
        .client_writedata          (c_wd),
        .client_accepted           (c_acc),
        .client_readvalid          (c_rv),
        .client_readdata           (c_rdata),
        .err_underflow             (err),
        .new_sdram_controller_0_s1 (s1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int c, input bit rd, input bit wr, input logic [23:0] a, input logic [15:0] d);
        c_rd[c] = rd;
        c_wr[c] = wr;
        c_addr[c*AW +: AW] = a;
        c_wd[c*16 +: 16] = d;
    endtask

    // Cycle model: one latched command slot, a queue of read tags in issue order.
    typedef struct { int cl; bit lane; } tag_t;
    bit          m_on = 0;
    bit          m_pend = 0, m_wr = 0, m_lane = 0;
    int          m_cl = 0, m_ptr = 0;
    logic [22:0] m_addr = '0;
    logic [15:0] m_wd = '0;
    tag_t        m_tags[$];
    bit          m_rv = 0;
    int          m_rvc = 0;
    logic [15:0] m_rd = '0;
    bit          m_err = 0;
    logic [N-1:0] e_acc, e_rv;
    int          n0, c;
    bit          fnd;
    tag_t        t;

    always @(negedge clk) begin
        if (m_on) begin
            e_acc = '0;
            if (m_pend && !s1.waitrequest) e_acc[m_cl] = 1'b1;
            e_rv = '0;
            if (m_rv) e_rv[m_rvc] = 1'b1;
            chk("read_n", 32'(s1.read_n), 32'(!(m_pend && !m_wr)));
            chk("write_n", 32'(s1.write_n), 32'(!(m_pend && m_wr)));
            chk("byteenable_n", 32'(s1.byteenable_n), m_pend ? (m_lane ? 32'h3 : 32'hC) : 32'hF);
            chk("chipselect", 32'(s1.chipselect), 32'h1);
            if (m_pend) begin
                chk("address", 32'(s1.address), 32'(m_addr));
                chk("writedata", s1.writedata, m_lane ? {m_wd, 16'h0} : {16'h0, m_wd});
            end
            chk("accepted", 32'(c_acc), 32'(e_acc));
            chk("readvalid", 32'(c_rv), 32'(e_rv));
            chk("readdata", 32'(c_rdata), 32'(m_rd));
            chk("err_underflow", 32'(err), 32'(m_err));

            if (rst) begin
                m_pend = 0; m_tags.delete(); m_rv = 0; m_rd = '0; m_err = 0; m_ptr = 0;
            end else begin
                n0 = m_tags.size();
                m_rv = 0;
                if (s1.readdatavalid) begin
                    if (n0 > 0) begin
                        t = m_tags.pop_front();
                        m_rv = 1; m_rvc = t.cl;
                        m_rd = t.lane ? s1.readdata[31:16] : s1.readdata[15:0];
                    end else begin
                        m_err = 1;
                    end
                end
                if (m_pend) begin
                    if (!s1.waitrequest) begin
                        if (!m_wr) m_tags.push_back('{cl: m_cl, lane: m_lane});
                        m_pend = 0;
                    end
                end else begin
                    fnd = 0;
                    for (int k = 0; k < N; k++) begin
`ifdef SDRAM_MUX_BUS_FIXED_PRIO_EN
                        c = k;
`else
                        c = (m_ptr + k) % N;
`endif
                        if (!fnd && (c_wr[c] || (c_rd[c] && n0 < MAXO))) begin
                            fnd = 1;
                            m_pend = 1; m_cl = c; m_wr = c_wr[c];
                            m_addr = c_addr[c*AW + 1 +: AW-1];
                            m_lane = c_addr[c*AW];
                            m_wd = c_wd[c*16 +: 16];
                            m_ptr = (c + 1) % N;
                        end
                    end
                end
            end
        end
    end

    int  n, n0a, n1a, sl_cnt, r;
    int  grants[4];
    bit  ok, rdacc;
    logic [N-1:0] acc_s;

    initial begin
        rst = 1'b1; c_addr = '0; c_rd = '0; c_wr = '0; c_wd = '0;
        s1.readdata = '0; s1.readdatavalid = 1'b0; s1.waitrequest = 1'b0;
        @(posedge clk); #1; m_on = 1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_read_n", 32'(s1.read_n), 32'h1);
        chk("rst_write_n", 32'(s1.write_n), 32'h1);
        chk("rst_be_n", 32'(s1.byteenable_n), 32'hF);
        chk("rst_address", 32'(s1.address), 32'h0);
        chk("rst_writedata", s1.writedata, 32'h0);
        chk("rst_acc_rv", 32'({c_acc, c_rv}), 32'h0);
        chk("rst_rdata", 32'(c_rdata), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Lane-1 write, no wait states: command and accept in cycle 1.
        @(posedge clk); #1; set_req(0, 0, 1, 24'h000003, 16'hBEEF);
        @(posedge clk); @(negedge clk); #1;
        chk("wr_write_n", 32'(s1.write_n), 32'h0);
        chk("wr_address", 32'(s1.address), 32'h1);
        chk("wr_be_n", 32'(s1.byteenable_n), 32'h3);
        chk("wr_writedata", s1.writedata, 32'hBEEF0000);
        chk("wr_accepted", 32'(c_acc), 32'h1);
        set_req(0, 0, 0, 24'h0, 16'h0);

        // Lane-0 read under 3 wait cycles; request dropped after the latch.
        @(posedge clk); #1; set_req(1, 1, 0, 24'h000010, 16'h0); s1.waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) c_rd[1] = 1'b0;
            if (k == 4) s1.waitrequest = 1'b0;
            @(negedge clk); #1;
            chk("rd_hold_read_n", 32'(s1.read_n), 32'h0);
            chk("rd_hold_address", 32'(s1.address), 32'h8);
            chk("rd_hold_acc", 32'(c_acc), (k == 4) ? 32'h2 : 32'h0);
        end
        @(posedge clk); #1; s1.readdatavalid = 1'b1; s1.readdata = 32'h12345678;
        @(posedge clk); #1; s1.readdatavalid = 1'b0;
        @(negedge clk); #1;
        chk("rd_ret_valid", 32'(c_rv), 32'h2);
        chk("rd_ret_data", 32'(c_rdata), 32'h5678);

        // Both clients writing continuously.
        @(posedge clk); #1; set_req(0, 0, 1, 24'h000100, 16'h1111); set_req(1, 0, 1, 24'h000201, 16'h2222);
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk); #1;
            if (c_acc != '0) begin
                grants[n] = c_acc[1] ? 1 : 0;
                n++;
                if (n == 4) begin c_wr = '0; end
            end
        end
        chk("arb_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_MUX_BUS_FIXED_PRIO_EN
            chk("arb_grant", 32'(grants[i]), 32'd0);
`else
            chk("arb_grant", 32'(grants[i]), 32'(i % 2));
`endif
        end

        // Read hold-off at MAX_OUTSTANDING; writes still pass.
        @(posedge clk); #1; set_req(0, 1, 0, 24'h000020, 16'h0);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk); #1;
            if (c_acc[0]) n++;
        end
        chk("holdoff_first4", 32'(n), 32'd4);
        set_req(1, 0, 1, 24'h000031, 16'hA5A5);
        n0a = 0; n1a = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (c_acc[0]) n0a++;
            if (c_acc[1]) begin n1a++; set_req(1, 0, 0, 24'h0, 16'h0); end
        end
        chk("holdoff_read_blocked", 32'(n0a), 32'd0);
        chk("holdoff_write_passes", 32'(n1a), 32'd1);
        @(posedge clk); #1; s1.readdatavalid = 1'b1; s1.readdata = 32'hCAFE0001;
        @(posedge clk); #1; s1.readdatavalid = 1'b0;
        @(negedge clk); #1;
        chk("holdoff_pop_valid", 32'(c_rv), 32'h1);
        chk("holdoff_pop_data", 32'(c_rdata), 32'h0001);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk); #1;
            if (c_acc[0]) ok = 1;
        end
        chk("holdoff_fifth_granted", 32'(ok), 32'h1);
        set_req(0, 0, 0, 24'h0, 16'h0);
        repeat (4) begin
            @(posedge clk); #1; s1.readdatavalid = 1'b1; s1.readdata = $urandom;
            @(posedge clk); #1; s1.readdatavalid = 1'b0;
        end

        // Stray beat after reset.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #1; chk("uf_err_clear", 32'(err), 32'h0);
        @(posedge clk); #1; s1.readdatavalid = 1'b1; s1.readdata = 32'hDEADBEEF;
        @(posedge clk); #1; s1.readdatavalid = 1'b0;
        @(negedge clk); #1;
        chk("uf_err_set", 32'(err), 32'h1);
        chk("uf_no_valid", 32'(c_rv), 32'h0);

        // Randomized traffic with a reset in the middle.
        sl_cnt = 0;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk); #1;
            acc_s = c_acc;
            rdacc = !s1.read_n && !s1.waitrequest;
            @(posedge clk); #1;
            if (rdacc) sl_cnt++;
            rst = (it >= 1500 && it < 1502);
            s1.readdatavalid = 1'b0;
            if (sl_cnt > 0 && $urandom_range(0, 2) == 0) begin
                s1.readdatavalid = 1'b1;
                s1.readdata = $urandom;
                sl_cnt--;
            end
            s1.waitrequest = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N; k++) begin
                if (rst || acc_s[k]) begin
                    c_rd[k] = 1'b0; c_wr[k] = 1'b0;
                end else if (!c_rd[k] && !c_wr[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r = $urandom_range(0, 3);
                        set_req(k, r != 1, r == 1 || r == 2, 24'($urandom), 16'($urandom));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    c_rd[k] = 1'b0; c_wr[k] = 1'b0;
                end
            end
        end

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
